pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 13 +
 rtl/pc_prio_sel.sv | 23 ++
 rtl/pc_gen.sv | 89 ++++++++
 tb/tb_pc_gen.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared defaults and redirect-source indices for the PC generator.
package pc_gen_pkg;

    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_INC       = 4;
    localparam int unsigned DEF_RESET_VEC = 0;

    // Redirect source indices; a lower index has higher priority.
    localparam int unsigned SRC_EXC    = 0;
    localparam int unsigned SRC_JUMP   = 1;
    localparam int unsigned SRC_BRANCH = 2;

endpackage

// File: rtl/pc_prio_sel.sv
// Fixed-priority redirect select: the lowest asserted index wins. Purely combinational.
module pc_prio_sel #(
    parameter int unsigned NSRC   = 3,
    parameter int unsigned ADDR_W = 32
) (
    input  logic [NSRC-1:0]        i_valid,
    input  logic [NSRC*ADDR_W-1:0] i_addr,
    output logic                   o_any_valid,
    output logic [ADDR_W-1:0]      o_addr
);

    always_comb begin
        o_any_valid = 1'b0;
        o_addr      = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (i_valid[k] && !o_any_valid) begin
                o_any_valid = 1'b1;
                o_addr      = i_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: prioritised redirects, stall with a single pending
// redirect slot, and a flag for misaligned applied redirects.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned        ADDR_W    = DEF_ADDR_W,
    parameter int unsigned        NSRC      = 3,
    parameter int unsigned        INC       = DEF_INC,
    parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(DEF_RESET_VEC)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic [NSRC-1:0]        redir_valid_i,
    input  logic [NSRC*ADDR_W-1:0] redir_addr_i,
    output logic [ADDR_W-1:0]      pc_o,
    output logic [ADDR_W-1:0]      pc_next_o,
    output logic                   pend_o,
    output logic                   misalign_o
);

    // INC is a power of two, so INC-1 covers exactly the low alignment bits.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INC - 1);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pend_addr;
    logic              r_pend;
    logic              r_pend_mis;
    logic              r_misalign;

    logic              w_any_valid;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [ADDR_W-1:0] w_live_addr;
    logic              w_live_mis;
    logic [ADDR_W-1:0] w_pc_next;

    pc_prio_sel #(
        .NSRC   (NSRC),
        .ADDR_W (ADDR_W)
    ) u_prio_sel (
        .i_valid     (redir_valid_i),
        .i_addr      (redir_addr_i),
        .o_any_valid (w_any_valid),
        .o_addr      (w_sel_addr)
    );

    assign w_live_addr = w_sel_addr & ~LOW_MASK;
    assign w_live_mis  = |(w_sel_addr & LOW_MASK);

    always_comb begin
        w_pc_next = r_pc + ADDR_W'(INC);
        if (w_any_valid) begin
            w_pc_next = w_live_addr;
        end else if (r_pend) begin
            w_pc_next = r_pend_addr;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc        <= RESET_VEC;
            r_pend_addr <= '0;
            r_pend      <= 1'b0;
            r_pend_mis  <= 1'b0;
            r_misalign  <= 1'b0;
        end else if (stall_i) begin
            // Latest redirect seen during a stall replaces any older one.
            if (w_any_valid) begin
                r_pend_addr <= w_live_addr;
                r_pend_mis  <= w_live_mis;
                r_pend      <= 1'b1;
            end
        end else begin
            r_pc   <= w_pc_next;
            r_pend <= 1'b0;
            if (w_any_valid) begin
                r_misalign <= w_live_mis;
            end else if (r_pend) begin
                r_misalign <= r_pend_mis;
            end
        end
    end

    assign pc_o       = r_pc;
    assign pc_next_o  = w_pc_next;
    assign pend_o     = r_pend;
    assign misalign_o = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expected values.
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned NS = 3;

    logic               clk;
    logic               rst;
    logic               stall;
    logic [NS-1:0]      valid;
    logic [NS*AW-1:0]   addr;
    logic [AW-1:0]      pc;
    logic [AW-1:0]      pc_next;
    logic               pend;
    logic               mis;

    int n_tests = 0;
    int n_fail  = 0;

    pc_gen #(
        .ADDR_W    (AW),
        .NSRC      (NS),
        .INC       (4),
        .RESET_VEC (32'h0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .redir_valid_i (valid),
        .redir_addr_i  (addr),
        .pc_o          (pc),
        .pc_next_o     (pc_next),
        .pend_o        (pend),
        .misalign_o    (mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input int unsigned src, input logic [31:0] a);
        valid      = '0;
        valid[src] = 1'b1;
        addr[src*AW +: AW] = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        valid = '0;
        addr  = '0;
        #12;
        check_eq("reset_pc", pc, 32'h0);
        check_eq("reset_pend", {31'b0, pend}, 32'h0);
        check_eq("reset_mis", {31'b0, mis}, 32'h0);
        rst = 1'b0;

        // Free-running sequence
        step(); check_eq("seq_4", pc, 32'h4);
        step(); check_eq("seq_8", pc, 32'h8);
        step(); check_eq("seq_c", pc, 32'hC);
        step(); check_eq("seq_10", pc, 32'h10);

        // Jump beats branch
        valid = 3'b110;
        addr[SRC_JUMP*AW +: AW]   = 32'h200;
        addr[SRC_BRANCH*AW +: AW] = 32'h300;
        #1 check_eq("prio_next", pc_next, 32'h200);
        step(); check_eq("prio_pc", pc, 32'h200);
        check_eq("prio_mis", {31'b0, mis}, 32'h0);
        valid = '0;

        // Stall with two redirects; the newer one is kept
        stall = 1'b1;
        redir(SRC_BRANCH, 32'h400);
        step(); check_eq("stall1_pc", pc, 32'h200);
        check_eq("stall1_pend", {31'b0, pend}, 32'h1);
        redir(SRC_JUMP, 32'h500);
        step(); check_eq("stall2_pc", pc, 32'h200);
        valid = '0;
        step(); check_eq("stall3_pc", pc, 32'h200);
        check_eq("stall3_pend", {31'b0, pend}, 32'h1);
        check_eq("stall3_next", pc_next, 32'h500);
        stall = 1'b0;
        step(); check_eq("release_pc", pc, 32'h500);
        check_eq("release_pend", {31'b0, pend}, 32'h0);

        // Lower-priority newer redirect overwrites, then live exception wins at release
        stall = 1'b1;
        redir(SRC_JUMP, 32'h600);
        step();
        redir(SRC_BRANCH, 32'h540);
        step();
        valid = '0;
        #1 check_eq("overwrite_next", pc_next, 32'h540);
        stall = 1'b0;
        redir(SRC_EXC, 32'h80);
        #1 check_eq("live_wins_next", pc_next, 32'h80);
        step(); check_eq("live_wins_pc", pc, 32'h80);
        check_eq("live_wins_pend", {31'b0, pend}, 32'h0);
        valid = '0;
        step(); check_eq("discard_pc", pc, 32'h84);

        // Wraparound, then misaligned redirect
        redir(SRC_EXC, 32'hFFFF_FFFC);
        step(); check_eq("wrap_pre", pc, 32'hFFFF_FFFC);
        valid = '0;
        step(); check_eq("wrap_pc", pc, 32'h0);
        check_eq("wrap_mis", {31'b0, mis}, 32'h0);
        redir(SRC_BRANCH, 32'h123);
        step(); check_eq("misal_pc", pc, 32'h120);
        check_eq("misal_mis", {31'b0, mis}, 32'h1);
        valid = '0;
        step(); check_eq("misal_hold_pc", pc, 32'h124);
        check_eq("misal_hold", {31'b0, mis}, 32'h1);
        redir(SRC_JUMP, 32'h700);
        step(); check_eq("align_pc", pc, 32'h700);
        check_eq("align_mis", {31'b0, mis}, 32'h0);

        // Misaligned pending redirect flags only once applied
        stall = 1'b1;
        redir(SRC_EXC, 32'h802);
        step(); check_eq("pmis_wait", {31'b0, mis}, 32'h0);
        valid = '0;
        stall = 1'b0;
        step(); check_eq("pmis_pc", pc, 32'h800);
        check_eq("pmis_mis", {31'b0, mis}, 32'h1);

        // Async reset mid-period while a redirect is pending
        stall = 1'b1;
        redir(SRC_EXC, 32'h900);
        step();
        valid = '0;
        check_eq("pre_rst_pend", {31'b0, pend}, 32'h1);
        #2 rst = 1'b1;
        #1 check_eq("arst_pc", pc, 32'h0);
        check_eq("arst_pend", {31'b0, pend}, 32'h0);
        check_eq("arst_mis", {31'b0, mis}, 32'h0);
        stall = 1'b0;
        #1 rst = 1'b0;
        step(); check_eq("post_rst_pc", pc, 32'h4);
        check_eq("post_rst_pend", {31'b0, pend}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
